port_arbiter: RTL and testbench
===============================

PORT_ARBITER -- requirements
Module: port_arbiter

Parameters
REQ-001 SHALL have parameter CNT_W, default 16, width of saturating grant/conflict counters.

Interface
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have read_a  input  1  port A (instruction) read request, held until resp_a.
REQ-005 SHALL have address_a  input  16  port A word address.
REQ-006 SHALL have resp_a  output  1  port A completion pulse.
REQ-007 SHALL have rdata_a  output  16  port A read data, valid while resp_a=1.
REQ-008 SHALL have read_b, write_b  input  1 each  port B (data) requests, held until resp_b; never both 1.
REQ-009 SHALL have wmask_b  input  2  port B byte-write mask.
REQ-010 SHALL have address_b, wdata_b  input  16 each  port B address and write data.
REQ-011 SHALL have resp_b  output  1  port B completion pulse.
REQ-012 SHALL have rdata_b  output  16  port B read data, valid while resp_b=1.
REQ-013 SHALL have mem_read, mem_write  output  1 each  downstream request, held until mem_resp.
REQ-014 SHALL have mem_wmask  output  2;  mem_address, mem_wdata  output  16 each  downstream request fields.
REQ-015 SHALL have mem_resp  input  1;  mem_rdata  input  16  downstream completion and read data.
REQ-016 SHALL have grant_a_count, grant_b_count, conflict_count  output  CNT_W each, plus matching *_reset inputs of width 1.

Function
REQ-017 SHALL implement FSM states IDLE, SERVE, RESP.
REQ-018 IDLE: no pending request -> stay; request on A only or B only -> grant that port; both -> grant port not granted last (round-robin, last_grant flag).
REQ-019 On grant, SHALL register port select, address, wdata, wmask, op (read/write) and enter SERVE next edge; port A grants always read, wmask=2'b11.
REQ-020 SERVE: mem_read/mem_write and mem_* fields driven only from the registered copies, stable until mem_resp.
REQ-021 SERVE with mem_resp=1: SHALL capture mem_rdata into the granted port's rdata register, drop mem_read/mem_write next cycle, enter RESP.
REQ-022 RESP: SHALL assert resp of granted port for exactly one cycle, other resp 0, then return to IDLE.
REQ-023 Latency: request first seen in IDLE cycle N -> mem_* asserted N+1; mem_resp in cycle M -> resp_x in M+1; minimum 3 cycles request-to-resp.
REQ-024 SHALL NOT re-sample requests in RESP; IDLE after RESP evaluates the CPU's updated request (repeat of the same address is a new transaction).
REQ-025 Request deassert during SERVE SHALL NOT abort; downstream completes and resp still pulses.
REQ-026 rdata_x SHALL hold last captured value outside resp cycles; write transactions leave rdata_b unchanged.
REQ-027 grant_a_count/grant_b_count SHALL increment per grant; conflict_count per IDLE cycle with both ports requesting; saturate at all-ones.
REQ-028 Each *_reset input SHALL synchronously clear its counter; clear wins over simultaneous increment.
REQ-029 mem_resp outside SERVE SHALL be ignored.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state IDLE, last_grant=A (so B wins first conflict), all outputs and counters 0, rdata_a=rdata_b=16'h0000.
REQ-031 Reset mid-SERVE SHALL drop mem_read/mem_write immediately; no resp issued for the aborted transaction.

Verification
REQ-032 A-only read addr 16'h0040, mem_resp 2 cycles after mem_read, mem_rdata 16'h1234 -> mem_address 16'h0040, resp_a one cycle, rdata_a 16'h1234, grant_a_count 1.
REQ-033 B write addr 16'h0100 wdata 16'hBEEF wmask 2'b01 -> mem_write=1 with those values held until mem_resp, resp_b one cycle, rdata_b unchanged.
REQ-034 Both request in same cycle after reset -> B served first, then A; conflict_count 1, both grant counts 1.
REQ-035 Continuous dual requests for 4 transactions -> grant order B,A,B,A; no resp overlap; each resp exactly one cycle.
REQ-036 reset_n low during SERVE with mem_resp arriving afterward -> no resp_a/resp_b, mem_read 0, counters 0, FSM IDLE.
REQ-037 grant_a_count at all-ones plus new A grant -> stays all-ones; grant_a_count_reset asserted same cycle -> 0.

Source files
------------

// File: rtl/port_arbiter.sv
// Arbitrates an instruction port (A, read-only) and a data port (B) onto one downstream
// memory port: one transaction in flight, round-robin on conflict, saturating statistics.
module port_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             read_a,
    input  logic [15:0]      address_a,
    output logic             resp_a,
    output logic [15:0]      rdata_a,
    input  logic             read_b,
    input  logic             write_b,
    input  logic [1:0]       wmask_b,
    input  logic [15:0]      address_b,
    input  logic [15:0]      wdata_b,
    output logic             resp_b,
    output logic [15:0]      rdata_b,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_wmask,
    output logic [15:0]      mem_address,
    output logic [15:0]      mem_wdata,
    input  logic             mem_resp,
    input  logic [15:0]      mem_rdata,
    output logic [CNT_W-1:0] grant_a_count,
    output logic [CNT_W-1:0] grant_b_count,
    output logic [CNT_W-1:0] conflict_count,
    input  logic             grant_a_count_reset,
    input  logic             grant_b_count_reset,
    input  logic             conflict_count_reset
);
    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    state_t           state, state_nxt;
    logic             req_a, req_b;
    logic             grant, grant_b, conflict;
    logic             last_grant_b;
    logic             sel_p0, write_p0;
    logic [1:0]       wmask_p0;
    logic [15:0]      addr_p0, wdata_p0;
    logic [15:0]      rdata_a_q, rdata_b_q;
    logic [CNT_W-1:0] grant_a_cnt, grant_b_cnt, conflict_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign req_a = read_a;
    assign req_b = read_b | write_b;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_b   = 1'b0;
        conflict  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        resp_a    = 1'b0;
        resp_b    = 1'b0;
        case (state)
            IDLE: begin
                conflict = req_a && req_b;
                if (req_a || req_b) begin
                    grant     = 1'b1;
                    // On conflict B wins unless it was the last port served
                    grant_b   = req_b && (!req_a || !last_grant_b);
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                mem_read  = !write_p0;
                mem_write = write_p0;
                if (mem_resp) state_nxt = RESP;
            end
            RESP: begin
                resp_a    = !sel_p0;
                resp_b    = sel_p0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant stage: registered request copy that drives the downstream port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant_b <= 1'b0;
            sel_p0       <= 1'b0;
            write_p0     <= 1'b0;
            wmask_p0     <= 2'b00;
            addr_p0      <= 16'h0000;
            wdata_p0     <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (grant) begin
                sel_p0       <= grant_b;
                last_grant_b <= grant_b;
                write_p0     <= grant_b && write_b;
                wmask_p0     <= grant_b ? wmask_b : 2'b11;
                addr_p0      <= grant_b ? address_b : address_a;
                wdata_p0     <= grant_b ? wdata_b : 16'h0000;
            end
        end
    end

    // Completion stage: read data captured only for reads finishing in SERVE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_a_q <= 16'h0000;
            rdata_b_q <= 16'h0000;
        end else if (state == SERVE && mem_resp && !write_p0) begin
            if (sel_p0) rdata_b_q <= mem_rdata;
            else        rdata_a_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_a_cnt  <= '0;
            grant_b_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant_a_count_reset)      grant_a_cnt  <= '0;
            else if (grant && !grant_b)   grant_a_cnt  <= sat_inc(grant_a_cnt);
            if (grant_b_count_reset)      grant_b_cnt  <= '0;
            else if (grant && grant_b)    grant_b_cnt  <= sat_inc(grant_b_cnt);
            if (conflict_count_reset)     conflict_cnt <= '0;
            else if (conflict)            conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

    assign mem_wmask      = wmask_p0;
    assign mem_address    = addr_p0;
    assign mem_wdata      = wdata_p0;
    assign rdata_a        = rdata_a_q;
    assign rdata_b        = rdata_b_q;
    assign grant_a_count  = grant_a_cnt;
    assign grant_b_count  = grant_b_cnt;
    assign conflict_count = conflict_cnt;
endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: expected responses go into a scoreboard queue that a
// separate monitor drains whenever resp_a/resp_b fires.
module tb_port_arbiter;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             read_a, read_b, write_b;
    logic [15:0]      address_a, address_b, wdata_b;
    logic [1:0]       wmask_b;
    logic             resp_a, resp_b;
    logic [15:0]      rdata_a, rdata_b;
    logic             mem_read, mem_write, mem_resp;
    logic [1:0]       mem_wmask;
    logic [15:0]      mem_address, mem_wdata, mem_rdata;
    logic [CNT_W-1:0] grant_a_count, grant_b_count, conflict_count;
    logic             grant_a_count_reset, grant_b_count_reset, conflict_count_reset;

    always #5 clk = ~clk;

    port_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .grant_a_count(grant_a_count), .grant_b_count(grant_b_count),
        .conflict_count(conflict_count),
        .grant_a_count_reset(grant_a_count_reset), .grant_b_count_reset(grant_b_count_reset),
        .conflict_count_reset(conflict_count_reset)
    );

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int   resp_dly = 0;
    int   wait_cnt = 0;
    bit   resp_en  = 1'b1;
    bit   inject   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic [15:0] d);
        exp_t e;
        e.port = port;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [15:0] lookup(input logic [15:0] addr);
        case (addr)
            16'h0040: return 16'h1234;
            16'h0200: return 16'hAAAA;
            16'h0300: return 16'hBBBB;
            16'h0210: return 16'h1111;
            16'h0310: return 16'h2222;
            16'h0500: return 16'h5A5A;
            16'h0600: return 16'h0F0F;
            default:  return 16'h0000;
        endcase
    endfunction

    // Downstream memory model: answers resp_dly cycles after the request appears
    initial begin
        mem_resp  = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (mem_resp) begin
                mem_resp = 1'b0;
                wait_cnt = 0;
            end else if (inject) begin
                mem_resp  = 1'b1;
                mem_rdata = 16'hFFFF;
                inject    = 1'b0;
            end else if (resp_en && (mem_read || mem_write)) begin
                if (wait_cnt >= resp_dly) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_read ? lookup(mem_address) : 16'hDEAD;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_a || resp_b) begin
                check("resp_overlap", 32'(resp_a & resp_b), 32'd0);
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", {30'd0, resp_b, resp_a}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_port", 32'(resp_b), 32'(e.port));
                    check("resp_rdata", 32'(resp_b ? rdata_b : rdata_a), 32'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // which: 0 = resp_a, 1 = resp_b, 2 = either
    task automatic wait_resp(input int which, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if ((which == 0 && resp_a) || (which == 1 && resp_b) ||
                (which == 2 && (resp_a || resp_b))) begin
                cyc = i;
                break;
            end
        end
        check("resp_seen", 32'(cyc != 0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_a_read(input logic [15:0] addr, input logic [15:0] exp_d);
        int c;
        push_exp(1'b0, exp_d);
        address_a = addr;
        read_a    = 1'b1;
        wait_resp(0, c);
        read_a    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset_n = 1'b0;
        read_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
        address_a = 16'h0; address_b = 16'h0; wdata_b = 16'h0; wmask_b = 2'b00;
        grant_a_count_reset = 1'b0; grant_b_count_reset = 1'b0; conflict_count_reset = 1'b0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_resp", {30'd0, resp_b, resp_a}, 32'd0);
        check("rst_rdata", {rdata_a, rdata_b}, 32'd0);
        check("rst_counts", 32'({grant_a_count, grant_b_count, conflict_count}), 32'd0);
        check("rst_mem_fields", {mem_address, mem_wdata}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // A-only read, response two cycles after mem_read
        push_exp(1'b0, 16'h1234);
        resp_dly  = 2;
        address_a = 16'h0040;
        read_a    = 1'b1;
        @(negedge clk);
        check("a_mem_read_idle", 32'(mem_read), 32'd0);
        @(negedge clk);
        check("a_mem_read", 32'(mem_read), 32'd1);
        check("a_mem_write", 32'(mem_write), 32'd0);
        check("a_mem_address", 32'(mem_address), 32'h0040);
        check("a_mem_wmask", 32'(mem_wmask), 32'd3);
        wait_resp(0, c);
        read_a = 1'b0;
        check("a_resp_latency", 32'(c), 32'd3);
        @(negedge clk);
        check("a_resp_one_cycle", 32'(resp_a), 32'd0);
        check("a_rdata_hold", 32'(rdata_a), 32'h1234);
        check("a_grant_count", 32'(grant_a_count), 32'd1);
        check("a_grant_b_count", 32'(grant_b_count), 32'd0);
        tick();

        // B write: fields held until mem_resp, rdata_b untouched
        push_exp(1'b1, 16'h0000);
        resp_dly  = 1;
        write_b   = 1'b1;
        address_b = 16'h0100;
        wdata_b   = 16'hBEEF;
        wmask_b   = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("b_mem_write", 32'(mem_write), 32'd1);
        check("b_mem_read", 32'(mem_read), 32'd0);
        check("b_mem_address", 32'(mem_address), 32'h0100);
        check("b_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check("b_mem_wmask", 32'(mem_wmask), 32'd1);
        @(negedge clk);
        check("b_held_write", 32'(mem_write), 32'd1);
        check("b_held_wdata", 32'(mem_wdata), 32'hBEEF);
        wait_resp(1, c);
        write_b = 1'b0;
        check("b_resp_latency", 32'(c), 32'd1);
        @(negedge clk);
        check("b_mem_write_drop", 32'(mem_write), 32'd0);
        check("b_rdata_unchanged", 32'(rdata_b), 32'h0000);
        check("b_grant_count", 32'(grant_b_count), 32'd1);
        tick();

        // Simultaneous requests after reset: B first, then A
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        push_exp(1'b1, 16'hBBBB);
        push_exp(1'b0, 16'hAAAA);
        address_a = 16'h0200;
        address_b = 16'h0300;
        read_a    = 1'b1;
        read_b    = 1'b1;
        wait_resp(1, c);
        read_b = 1'b0;
        wait_resp(0, c);
        read_a = 1'b0;
        @(negedge clk);
        check("dual_conflict_count", 32'(conflict_count), 32'd1);
        check("dual_grant_a", 32'(grant_a_count), 32'd1);
        check("dual_grant_b", 32'(grant_b_count), 32'd1);
        tick();

        // Continuous dual requests: B, A, B, A
        push_exp(1'b1, 16'h2222);
        push_exp(1'b0, 16'h1111);
        push_exp(1'b1, 16'h2222);
        push_exp(1'b0, 16'h1111);
        resp_dly  = 0;
        address_a = 16'h0210;
        address_b = 16'h0310;
        read_a    = 1'b1;
        read_b    = 1'b1;
        for (int k = 0; k < 4; k++) wait_resp(2, c);
        read_a = 1'b0;
        read_b = 1'b0;
        @(negedge clk);
        check("rr_conflict_count", 32'(conflict_count), 32'd5);
        check("rr_grant_a", 32'(grant_a_count), 32'd3);
        check("rr_grant_b", 32'(grant_b_count), 32'd3);
        tick();
        conflict_count_reset = 1'b1;
        grant_b_count_reset  = 1'b1;
        tick();
        conflict_count_reset = 1'b0;
        grant_b_count_reset  = 1'b0;
        @(negedge clk);
        check("clr_conflict", 32'(conflict_count), 32'd0);
        check("clr_grant_b", 32'(grant_b_count), 32'd0);
        check("clr_grant_a_kept", 32'(grant_a_count), 32'd3);
        tick();

        // Reset while SERVE, late mem_resp must be ignored
        resp_en   = 1'b0;
        address_a = 16'h0400;
        read_a    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_mem_read_pre", 32'(mem_read), 32'd1);
        #2;
        reset_n = 1'b0;
        read_a  = 1'b0;
        #1;
        check("abort_mem_read_async", 32'(mem_read), 32'd0);
        check("abort_counts", 32'({grant_a_count, grant_b_count, conflict_count}), 32'd0);
        check("abort_rdata_a", 32'(rdata_a), 32'h0000);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        inject = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_mem_read_post", 32'(mem_read), 32'd0);
        check("abort_mem_write_post", 32'(mem_write), 32'd0);
        check("abort_grant_a", 32'(grant_a_count), 32'd0);
        resp_en = 1'b1;
        tick();

        // FSM back in IDLE: minimum-latency read
        push_exp(1'b0, 16'h0F0F);
        address_a = 16'h0600;
        read_a    = 1'b1;
        @(negedge clk);
        check("min_mem_read_idle", 32'(mem_read), 32'd0);
        @(negedge clk);
        check("min_mem_read", 32'(mem_read), 32'd1);
        check("min_mem_address", 32'(mem_address), 32'h0600);
        wait_resp(0, c);
        read_a = 1'b0;
        check("min_resp_latency", 32'(c), 32'd1);

        // Saturation of grant_a_count, then clear against a simultaneous grant
        for (int k = 0; k < 14; k++) do_a_read(16'h0500, 16'h5A5A);
        @(negedge clk);
        check("sat_grant_a_full", 32'(grant_a_count), 32'd15);
        tick();
        do_a_read(16'h0500, 16'h5A5A);
        @(negedge clk);
        check("sat_grant_a_hold", 32'(grant_a_count), 32'd15);
        tick();
        push_exp(1'b0, 16'h5A5A);
        address_a           = 16'h0500;
        read_a              = 1'b1;
        grant_a_count_reset = 1'b1;
        tick();
        grant_a_count_reset = 1'b0;
        @(negedge clk);
        check("clr_wins_grant_a", 32'(grant_a_count), 32'd0);
        wait_resp(0, c);
        read_a = 1'b0;
        @(negedge clk);
        check("clr_grant_a_after", 32'(grant_a_count), 32'd0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
